ntt_fifo_src_arbiter: RTL
=========================

# ntt_fifo_src_arbiter

Round-robin arbiter that shares the single source (write) port of a polynomial NTT FIFO between `NUM_REQ` producer engines (e.g. top-level RLWE loader, bootstrap accumulator, key-switch unit). A requester that wins arbitration owns the port for one whole polynomial, from grant until its `wr_finish` pulse. The arbiter sits between the producers and the FIFO's `myFIFO_NTT_source_if.to_FIFO` side. It muxes address, data and tag fields onto that port and blocks losers by reflecting `full`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `CNT_WIDTH`, 16: width of the completed-polynomial counter.

Ports (`LW` = `` `BIT_WIDTH*`LINE_SIZE ``; per-requester buses are packed `[NUM_REQ-1:0][W-1:0]`):
- `clk` input 1: the single clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `req_i` input NUM_REQ: request to write one polynomial.
- `grant_o` output NUM_REQ: one-hot ownership, registered.
- `full_o` output NUM_REQ: per-requester full.
- `addrA_i`, `addrB_i` input NUM_REQ×`ADDR_WIDTH`: requester write addresses.
- `dA_i`, `dB_i` input NUM_REQ×LW: requester write data.
- `wr_finish_i` input NUM_REQ: one-cycle end-of-polynomial pulse.
- `rlwe_id_i`, `poly_id_i`, `opcode_i` input NUM_REQ×(`RLWE_ID_WIDTH`/`POLY_ID_WIDTH`/`OPCODE_WIDTH`): polynomial tags.
- `fifo_addrA`, `fifo_addrB`, `fifo_dA`, `fifo_dB`, `fifo_wr_finish`, `fifo_rlwe_id`, `fifo_poly_id`, `fifo_opcode` output: drive the FIFO source port, same widths as the requester buses.
- `fifo_full` input 1: FIFO full.
- `busy_o` output 1: a grant is active.
- `grant_id_o` output $clog2(NUM_REQ): index of the current or last owner.
- `poly_cnt_o` output CNT_WIDTH: polynomials forwarded, wraps.

## Operation
State machine with three states:
- **IDLE**
  - If `fifo_full`=0 and `|req_i`: pick the first requesting index at or after `rr_ptr`, searching cyclically.
  - Register `grant_o` one-hot for that index and set `grant_id_o` to it.
  - Set `rr_ptr` = winner+1 mod NUM_REQ and go to GRANT.
  - If `fifo_full`=1: no grant, remain in IDLE.
- **GRANT**
  - All `fifo_*` outputs are combinationally muxed from requester `grant_id_o`.
  - `fifo_wr_finish` = `wr_finish_i[grant_id_o]`.
  - When that pulse is seen: clear `grant_o`, increment `poly_cnt_o`, go to RELEASE.
  - `req_i` of the owner is ignored after grant; dropping it does not release the port.
  - `wr_finish_i` from non-owners is ignored.
- **RELEASE**
  - One cycle, so the FIFO can update `fifo_full` after the slot commit.
  - Then go to IDLE.

Full handling:
- `full_o[i]` = `fifo_full` if `grant_o[i]`, else 1. Losers always see full.
- In IDLE and RELEASE, all `full_o` bits are 1.

Defaults: when no grant is active, `fifo_addr*`, `fifo_d*` and the tag outputs are 0 and `fifo_wr_finish` is 0.

`busy_o` = state is GRANT.

Reset (asynchronous, any time, including mid-polynomial):
- state IDLE, `grant_o`=0, `rr_ptr`=0, `grant_id_o`=0, `poly_cnt_o`=0.
- All `full_o`=1, `fifo_*`=0.
- A partially written polynomial is abandoned. The FIFO is reset by the same `rstn`.

## Timing
- Request latency: `req_i` high in IDLE at cycle t with `fifo_full`=0 gives `grant_o` high at t+1. The owner may write from t+1.
- Release latency: owner `wr_finish_i` at cycle t:
  - `fifo_wr_finish` at t (combinational pass-through);
  - `grant_o`=0 and `poly_cnt_o` updated at t+1 (RELEASE);
  - IDLE at t+2;
  - earliest next grant visible at t+3.
- Simultaneous requests resolve by `rr_ptr` only; there is no fixed priority.
- `poly_cnt_o` wraps from 2^CNT_WIDTH−1 to 0.
- Data paths are combinational muxes only. Only the state, grant, pointer and counter are registered.

## Structure
- Shared package `fhe_arb_pkg`:
  - `arb_state_e` {IDLE, GRANT, RELEASE};
  - a function `rr_pick(req, ptr)` returning the winner index.
  - Widths come from `common.vh`.
- One sub-module, `rr_arbiter`: a combinational round-robin picker with inputs `req`, `ptr` and outputs `valid`, `idx`. It is reusable by the sink-side arbiter.
- The top module holds the FSM, registers and output muxes.

## Test plan
- **Single requester:** NUM_REQ=2, `req_i`=01 at t0, `fifo_full`=0.
  - `grant_o`=01 at t1.
  - Requester 0 drives addrA=5, dA=0xABC; FIFO outputs match.
  - `wr_finish_i[0]` at t9 gives `fifo_wr_finish` at t9, `grant_o`=0 at t10, `poly_cnt_o`=1.
- **Contention:** `req_i`=11 held continuously.
  - Grants alternate 01, 10, 01.
  - Each grant starts exactly 3 cycles after the previous owner's finish.
  - `full_o` of the loser stays 1 throughout.
- **FIFO full:** `fifo_full`=1 with `req_i`=01.
  - No grant for 20 cycles.
  - Drop `fifo_full` at t20: grant at t21.
- **Stray signals:**
  - Non-owner pulses `wr_finish_i`: no state change and `fifo_wr_finish`=0.
  - Owner drops `req_i` mid-write: grant held until its `wr_finish_i`.
- **Reset mid-polynomial:** assert `rstn`=0 while in GRANT.
  - Immediately `grant_o`=0, `full_o`=all 1s, `poly_cnt_o`=0.
  - After release with `req_i`=10, requester 1 is granted (`rr_ptr` = 0, no requester 0).
- **Counter wrap:** CNT_WIDTH=4, 17 polynomials → `poly_cnt_o`=1.

Source files
------------

// File: rtl/ntt_fifo_src_arbiter_pkg.sv
// fhe_arb_pkg: shared widths, FSM state type and round-robin pick function
// used by the NTT FIFO source/sink arbiters.
//   ADDR_WIDTH, BIT_WIDTH, LINE_SIZE  - FIFO port geometry (LW = BIT_WIDTH*LINE_SIZE)
//   RLWE_ID_WIDTH, POLY_ID_WIDTH, OPCODE_WIDTH - polynomial tag widths
//   arb_state_e                       - IDLE / GRANT / RELEASE
//   rr_pick(req, ptr, n)              - first requesting index at or after ptr, cyclic over n
package fhe_arb_pkg;

   localparam int ADDR_WIDTH    = 10;
   localparam int BIT_WIDTH     = 12;
   localparam int LINE_SIZE     = 4;
   localparam int LW            = BIT_WIDTH * LINE_SIZE;
   localparam int RLWE_ID_WIDTH = 3;
   localparam int POLY_ID_WIDTH = 4;
   localparam int OPCODE_WIDTH  = 3;
   localparam int MAX_REQ       = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   // Scan ptr, ptr+1, ... (mod n) and return the first index with req set.
   function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         ptr,
                                          input int                 n);
      logic [2:0] win;
      logic       found;
      int         idx;
      win   = 3'd0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = (int'(ptr) + k) % n;
         if (!found && (k < n) && req[idx[2:0]]) begin
            win   = idx[2:0];
            found = 1'b1;
         end else begin
            win   = win;
            found = found;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/ntt_fifo_src_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, shared by source and sink arbiters.
//   req   [N-1:0]  - request vector
//   ptr   [IW-1:0] - index with highest priority this round
//   valid          - at least one request present
//   idx   [IW-1:0] - winning index (meaningful only when valid)
module rr_arbiter
   import fhe_arb_pkg::*;
#(
   parameter int N = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [MAX_REQ-1:0] req_pad_s;
   logic [2:0]         ptr_pad_s;
   logic [2:0]         win_s;

   // Widen to the package's fixed search width and pick the winner.
   always_comb begin
      req_pad_s          = {MAX_REQ{1'b0}};
      req_pad_s[N-1:0]   = req;
      ptr_pad_s          = 3'(ptr);
      win_s              = rr_pick(req_pad_s, ptr_pad_s, N);
      valid              = |req;
      idx                = win_s[IW-1:0];
   end

endmodule

// File: rtl/ntt_fifo_src_arbiter.sv
// ntt_fifo_src_arbiter: shares the NTT FIFO source (write) port between NUM_REQ
// producers. A winner owns the port for one whole polynomial, from grant until
// its wr_finish pulse; everyone else sees full.
//   clk, rstn                    - clock, async active-low reset
//   req_i / grant_o / full_o     - per-requester handshake (grant_o one-hot, registered)
//   addrA_i..opcode_i            - per-requester write buses
//   fifo_*                       - muxed FIFO source port, fifo_full back from FIFO
//   busy_o, grant_id_o           - grant active, current/last owner index
//   poly_cnt_o                   - polynomials forwarded (wraps)
module ntt_fifo_src_arbiter
   import fhe_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int CNT_WIDTH = 16,
   localparam int IDW      = $clog2(NUM_REQ)
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic [NUM_REQ-1:0]                     req_i,
   output logic [NUM_REQ-1:0]                     grant_o,
   output logic [NUM_REQ-1:0]                     full_o,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addrA_i,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addrB_i,
   input  logic [NUM_REQ-1:0][LW-1:0]             dA_i,
   input  logic [NUM_REQ-1:0][LW-1:0]             dB_i,
   input  logic [NUM_REQ-1:0]                     wr_finish_i,
   input  logic [NUM_REQ-1:0][RLWE_ID_WIDTH-1:0]  rlwe_id_i,
   input  logic [NUM_REQ-1:0][POLY_ID_WIDTH-1:0]  poly_id_i,
   input  logic [NUM_REQ-1:0][OPCODE_WIDTH-1:0]   opcode_i,
   output logic [ADDR_WIDTH-1:0]                  fifo_addrA,
   output logic [ADDR_WIDTH-1:0]                  fifo_addrB,
   output logic [LW-1:0]                          fifo_dA,
   output logic [LW-1:0]                          fifo_dB,
   output logic                                   fifo_wr_finish,
   output logic [RLWE_ID_WIDTH-1:0]               fifo_rlwe_id,
   output logic [POLY_ID_WIDTH-1:0]               fifo_poly_id,
   output logic [OPCODE_WIDTH-1:0]                fifo_opcode,
   input  logic                                   fifo_full,
   output logic                                   busy_o,
   output logic [IDW-1:0]                         grant_id_o,
   output logic [CNT_WIDTH-1:0]                   poly_cnt_o
);

   arb_state_e           state_r;
   logic [NUM_REQ-1:0]   grant_r;
   logic [IDW-1:0]       grant_id_r;
   logic [IDW-1:0]       rr_ptr_r;
   logic [CNT_WIDTH-1:0] poly_cnt_r;

   logic                 pick_valid_s;
   logic [IDW-1:0]       pick_idx_s;
   logic                 busy_s;

   rr_arbiter #(.N(NUM_REQ)) u_pick (
      .req   (req_i),
      .ptr   (rr_ptr_r),
      .valid (pick_valid_s),
      .idx   (pick_idx_s)
   );

   // Arbitration FSM: grant on a free FIFO, hold until owner's finish, one release cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r    <= IDLE;
         grant_r    <= {NUM_REQ{1'b0}};
         grant_id_r <= {IDW{1'b0}};
         rr_ptr_r   <= {IDW{1'b0}};
         poly_cnt_r <= {CNT_WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (!fifo_full && pick_valid_s) begin
                  grant_r    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                  grant_id_r <= pick_idx_s;
                  // NUM_REQ need not be a power of two, so wrap explicitly.
                  rr_ptr_r   <= (pick_idx_s == IDW'(NUM_REQ-1)) ? {IDW{1'b0}}
                                                                 : pick_idx_s + IDW'(1);
                  state_r    <= GRANT;
               end
            end
            GRANT: begin
               // Only the owner's finish counts; its req_i is no longer looked at.
               if (wr_finish_i[grant_id_r]) begin
                  grant_r    <= {NUM_REQ{1'b0}};
                  poly_cnt_r <= poly_cnt_r + CNT_WIDTH'(1);
                  state_r    <= RELEASE;
               end
            end
            RELEASE: begin
               // Gives the FIFO a cycle to refresh fifo_full after the slot commit.
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               grant_r <= {NUM_REQ{1'b0}};
            end
         endcase
      end
   end

   assign busy_s     = (state_r == GRANT);
   assign busy_o     = busy_s;
   assign grant_o    = grant_r;
   assign grant_id_o = grant_id_r;
   assign poly_cnt_o = poly_cnt_r;

   // Owner sees the real FIFO full, losers (and everyone outside GRANT) see full.
   always_comb begin
      full_o = {NUM_REQ{1'b1}};
      if (busy_s) begin
         full_o = ~grant_r | {NUM_REQ{fifo_full}};
      end else begin
         full_o = {NUM_REQ{1'b1}};
      end
   end

   // Source-port mux from the owner; zeros whenever nobody owns the port.
   always_comb begin
      fifo_addrA     = {ADDR_WIDTH{1'b0}};
      fifo_addrB     = {ADDR_WIDTH{1'b0}};
      fifo_dA        = {LW{1'b0}};
      fifo_dB        = {LW{1'b0}};
      fifo_wr_finish = 1'b0;
      fifo_rlwe_id   = {RLWE_ID_WIDTH{1'b0}};
      fifo_poly_id   = {POLY_ID_WIDTH{1'b0}};
      fifo_opcode    = {OPCODE_WIDTH{1'b0}};
      if (busy_s) begin
         fifo_addrA     = addrA_i[grant_id_r];
         fifo_addrB     = addrB_i[grant_id_r];
         fifo_dA        = dA_i[grant_id_r];
         fifo_dB        = dB_i[grant_id_r];
         fifo_wr_finish = wr_finish_i[grant_id_r];
         fifo_rlwe_id   = rlwe_id_i[grant_id_r];
         fifo_poly_id   = poly_id_i[grant_id_r];
         fifo_opcode    = opcode_i[grant_id_r];
      end else begin
         fifo_wr_finish = 1'b0;
      end
   end

endmodule
